// File: rtl/block_ram_arbiter_pick.sv
// Round-robin first-grant finder: the lowest-distance requester from ptr that
// is valid and not masked wins.
module block_ram_arbiter_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   ptr,
  output logic               gnt_vld,
  output logic [IDX_W-1:0]   gnt_idx
);

  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    // Walk from farthest to nearest so the nearest eligible requester wins last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j] && !mask[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/block_ram_arbiter.sv
// Round-robin arbiter mapping up to two requests per cycle onto a true
// dual-port RAM, with 1-cycle read responses on a shared data bus.
module block_ram_arbiter #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int NUM_REQ    = 4
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [NUM_REQ-1:0]               REQ_VALID,
  input  logic [NUM_REQ-1:0]               REQ_WRITE,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    REQ_DATA,
  output logic [NUM_REQ-1:0]               REQ_READY,
  output logic [NUM_REQ-1:0]               RESP_VALID,
  output logic [DATA_WIDTH-1:0]            RESP_DATA,
  output logic [DATA_WIDTH-1:0]            DI_A,
  output logic [ADDR_WIDTH-1:0]            ADDR_A,
  output logic                             WE_A,
  output logic                             RE_A,
  input  logic [DATA_WIDTH-1:0]            DO_A,
  output logic [DATA_WIDTH-1:0]            DI_B,
  output logic [ADDR_WIDTH-1:0]            ADDR_B,
  output logic                             WE_B,
  output logic                             RE_B,
  input  logic [DATA_WIDTH-1:0]            DO_B
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
    logic             port_b;
  } resp_t;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data;
  logic [NUM_REQ-1:0]                 no_mask, mask1;
  logic [IDX_W-1:0]                   ptr_q, ptr_d, g0_idx, g1_idx;
  logic                               g0_vld, g1_vld, g0_wr, g1_wr, a_on, b_on;
  resp_t                              resp_q, resp_d;

  assign addr    = REQ_ADDR;
  assign data    = REQ_DATA;
  assign no_mask = '0;

  block_ram_arbiter_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick_a (
    .req(REQ_VALID), .mask(no_mask), .ptr(ptr_q), .gnt_vld(g0_vld), .gnt_idx(g0_idx)
  );

  assign g0_wr = REQ_WRITE[g0_idx];

  // Port B excludes G0 itself, address hazards with G0, and any second read
  // (both read responses would land on the one RESP_DATA bus together).
  always_comb begin
    mask1 = '0;
    for (int j = 0; j < NUM_REQ; j++)
      mask1[j] = (IDX_W'(j) == g0_idx)
              || (!REQ_WRITE[j] && !g0_wr)
              || ((addr[j] == addr[g0_idx]) && (REQ_WRITE[j] || g0_wr));
  end

  block_ram_arbiter_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick_b (
    .req(REQ_VALID), .mask(mask1), .ptr(ptr_q), .gnt_vld(g1_vld), .gnt_idx(g1_idx)
  );

  assign g1_wr = REQ_WRITE[g1_idx];
  assign a_on  = g0_vld && !RESET;
  assign b_on  = a_on && g1_vld;

  always_comb begin
    REQ_READY = '0;
    if (a_on) REQ_READY[g0_idx] = 1'b1;
    if (b_on) REQ_READY[g1_idx] = 1'b1;
  end

  assign WE_A   = a_on && g0_wr;
  assign RE_A   = a_on && !g0_wr;
  assign ADDR_A = a_on ? addr[g0_idx] : '0;
  assign DI_A   = WE_A ? data[g0_idx] : '0;

  assign WE_B   = b_on && g1_wr;
  assign RE_B   = b_on && !g1_wr;
  assign ADDR_B = b_on ? addr[g1_idx] : '0;
  assign DI_B   = WE_B ? data[g1_idx] : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (b_on)      ptr_d = next_idx(g1_idx);
    else if (a_on) ptr_d = next_idx(g0_idx);
  end

  always_comb begin
    resp_d = '0;
    if (RE_A)      resp_d = '{vld: 1'b1, idx: g0_idx, port_b: 1'b0};
    else if (RE_B) resp_d = '{vld: 1'b1, idx: g1_idx, port_b: 1'b1};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q  <= '0;
      resp_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      resp_q <= resp_d;
    end
  end

  always_comb begin
    RESP_VALID = '0;
    if (resp_q.vld && !RESET) RESP_VALID[resp_q.idx] = 1'b1;
  end

  assign RESP_DATA = resp_q.port_b ? DO_B : DO_A;

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Directed bench for block_ram_arbiter: vector table plus hand sequences,
// against a behavioural true dual-port RAM that corrupts on collisions.
module tb_block_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NR = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [NR-1:0] REQ_VALID, REQ_WRITE, REQ_READY, RESP_VALID;
  logic [NR*AW-1:0] REQ_ADDR;
  logic [NR*DW-1:0] REQ_DATA;
  logic [DW-1:0] RESP_DATA, DI_A, DI_B;
  logic [DW-1:0] DO_A = '0;
  logic [DW-1:0] DO_B = '0;
  logic [AW-1:0] ADDR_A, ADDR_B;
  logic          WE_A, RE_A, WE_B, RE_B;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  block_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .RESP_VALID(RESP_VALID), .RESP_DATA(RESP_DATA),
    .DI_A(DI_A), .ADDR_A(ADDR_A), .WE_A(WE_A), .RE_A(RE_A), .DO_A(DO_A),
    .DI_B(DI_B), .ADDR_B(ADDR_B), .WE_B(WE_B), .RE_B(RE_B), .DO_B(DO_B)
  );

  // Behavioural RAM: mem[a] starts as 0x10+a; write/write or read/write on one address gives X.
  logic [DW-1:0] mem [16];
  logic          mem_ok = 1'b0;
  always @(posedge CLK) begin
    if (!mem_ok) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
      mem_ok <= 1'b1;
    end else if (WE_A && WE_B && ADDR_A == ADDR_B) begin
      mem[ADDR_A] <= 'x;
    end else begin
      if (WE_A) mem[ADDR_A] <= DI_A;
      if (WE_B) mem[ADDR_B] <= DI_B;
    end
    if (RE_A) DO_A <= (WE_B && ADDR_B == ADDR_A) ? 'x : mem[ADDR_A];
    if (RE_B) DO_B <= (WE_A && ADDR_A == ADDR_B) ? 'x : mem[ADDR_B];
  end

  typedef struct packed {
    logic [3:0]  v, w;
    logic [15:0] a;
    logic [31:0] d;
    logic [35:0] ctl;  // {READY,WE_A,RE_A,ADDR_A,DI_A,WE_B,RE_B,ADDR_B,DI_B,RESP_VALID}
    logic [7:0]  rd;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, w, input logic [15:0] a, input logic [31:0] d,
                              input logic [3:0] rdy, input logic wea, rea, input logic [3:0] aa,
                              input logic [7:0] da, input logic web, reb, input logic [3:0] ab,
                              input logic [7:0] db, input logic [3:0] rv, input logic [7:0] rd);
    vec_t t;
    t.v = v; t.w = w; t.a = a; t.d = d; t.rd = rd;
    t.ctl = {rdy, wea, rea, aa, da, web, reb, ab, db, rv};
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive after the edge, sample comb outputs mid-cycle.
  task automatic cyc(input logic [3:0] v, w, input logic [15:0] a, input logic [31:0] d);
    @(posedge CLK); #1;
    RESET = 1'b0; REQ_VALID = v; REQ_WRITE = w; REQ_ADDR = a; REQ_DATA = d;
    #2;
    if (RESP_VALID != '0) begin
      chk("resp_x", 64'($isunknown(RESP_DATA)), 64'd0);
      chk("resp_onehot", 64'($countones(RESP_VALID)), 64'd1);
    end
  endtask

  task automatic do_reset();
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      RESET = 1'b1; REQ_VALID = 4'hF; REQ_WRITE = 4'h3; REQ_ADDR = 16'h3210; REQ_DATA = '0;
      #2;
      chk("rst_outputs", 64'({REQ_READY, RESP_VALID, WE_A, WE_B, RE_A, RE_B}), 64'd0);
    end
  endtask

  function automatic logic [35:0] cur_ctl();
    return {REQ_READY, WE_A, RE_A, ADDR_A, DI_A, WE_B, RE_B, ADDR_B, DI_B, RESP_VALID};
  endfunction

  vec_t tbl [12];

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; REQ_VALID = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_DATA = '0;
    //             v     w     addr      data          rdy  wea rea aa  da     web reb ab  db     rv    rd
    tbl[0]  = mk(4'h3, 4'h1, 16'h0065, 32'h0000000A, 4'h3, 1, 0, 5, 8'h0A, 0, 1, 6, 8'h00, 4'h0, 8'h00);
    tbl[1]  = mk(4'hF, 4'h0, 16'h4321, 32'h0,        4'h4, 0, 1, 3, 8'h00, 0, 0, 0, 8'h00, 4'h2, 8'h16);
    tbl[2]  = mk(4'hF, 4'h0, 16'h4321, 32'h0,        4'h8, 0, 1, 4, 8'h00, 0, 0, 0, 8'h00, 4'h4, 8'h13);
    tbl[3]  = mk(4'hF, 4'h0, 16'h4321, 32'h0,        4'h1, 0, 1, 1, 8'h00, 0, 0, 0, 8'h00, 4'h8, 8'h14);
    tbl[4]  = mk(4'h6, 4'h6, 16'h0990, 32'h00665500, 4'h2, 1, 0, 9, 8'h55, 0, 0, 0, 8'h00, 4'h1, 8'h11);
    tbl[5]  = mk(4'h4, 4'h4, 16'h0900, 32'h00660000, 4'h4, 1, 0, 9, 8'h66, 0, 0, 0, 8'h00, 4'h0, 8'h00);
    tbl[6]  = mk(4'h9, 4'h0, 16'h9009, 32'h0,        4'h8, 0, 1, 9, 8'h00, 0, 0, 0, 8'h00, 4'h0, 8'h00);
    tbl[7]  = mk(4'h1, 4'h0, 16'h0009, 32'h0,        4'h1, 0, 1, 9, 8'h00, 0, 0, 0, 8'h00, 4'h8, 8'h66);
    tbl[8]  = mk(4'h0, 4'h0, 16'h0000, 32'h0,        4'h0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 4'h1, 8'h66);
    tbl[9]  = mk(4'hE, 4'hC, 16'h4220, 32'h44770000, 4'hA, 0, 1, 2, 8'h00, 1, 0, 4, 8'h44, 4'h0, 8'h00);
    tbl[10] = mk(4'h4, 4'h4, 16'h0200, 32'h00770000, 4'h4, 1, 0, 2, 8'h77, 0, 0, 0, 8'h00, 4'h2, 8'h12);
    tbl[11] = mk(4'h0, 4'h0, 16'h0000, 32'h0,        4'h0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 4'h0, 8'h00);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d);
      chk($sformatf("row%0d ctl", i), 64'(cur_ctl()), 64'(tbl[i].ctl));
      if (tbl[i].ctl[3:0] != 4'h0) chk($sformatf("row%0d rdata", i), 64'(RESP_DATA), 64'(tbl[i].rd));
    end

    // All four read one address continuously: one grant per cycle, rotating.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cyc(4'hF, 4'h0, 16'h3333, 32'h0);
      chk($sformatf("rr%0d ready", c), 64'(REQ_READY), 64'(4'b1 << (c % 4)));
      chk($sformatf("rr%0d ports", c), 64'({RE_A, RE_B, WE_A, WE_B}), 64'(4'b1000));
      chk($sformatf("rr%0d resp", c), 64'(RESP_VALID), (c == 0) ? 64'd0 : 64'(4'b1 << ((c - 1) % 4)));
      if (c > 0) chk($sformatf("rr%0d rdata", c), 64'(RESP_DATA), 64'h13);
    end
    cyc(4'h0, 4'h0, 16'h0, 32'h0);

    // Write and read of one address in one cycle: the read waits and sees new data.
    do_reset();
    cyc(4'h3, 4'h1, 16'h0077, 32'h000000C3);
    chk("wr_rd ready0", 64'(REQ_READY), 64'h1);
    chk("wr_rd ports0", 64'({WE_A, RE_A, WE_B, RE_B}), 64'(4'b1000));
    cyc(4'h2, 4'h0, 16'h0070, 32'h0);
    chk("wr_rd ready1", 64'(REQ_READY), 64'h2);
    chk("wr_rd porta1", 64'({RE_A, ADDR_A}), 64'({1'b1, 4'h7}));
    cyc(4'h0, 4'h0, 16'h0, 32'h0);
    chk("wr_rd resp", 64'(RESP_VALID), 64'h2);
    chk("wr_rd rdata", 64'(RESP_DATA), 64'hC3);

    // Two writes from PTR=2 issue together on A and B; PTR wraps to 0.
    do_reset();
    cyc(4'h2, 4'h2, 16'h00F0, 32'h00005A00);
    chk("ww pre ready", 64'(REQ_READY), 64'h2);
    cyc(4'hC, 4'hC, 16'h2100, 32'h32210000);
    chk("ww ready", 64'(REQ_READY), 64'hC);
    chk("ww ports", 64'({WE_A, RE_A, ADDR_A, DI_A, WE_B, RE_B, ADDR_B, DI_B}),
        64'({1'b1, 1'b0, 4'h1, 8'h21, 1'b1, 1'b0, 4'h2, 8'h32}));
    cyc(4'hF, 4'h0, 16'h2121, 32'h0);
    chk("ww ptr wrap", 64'(REQ_READY), 64'h1);
    cyc(4'h0, 4'h0, 16'h0, 32'h0);
    chk("ww resp", 64'(RESP_VALID), 64'h1);
    chk("ww rdata", 64'(RESP_DATA), 64'h21);

    // Reset during an outstanding read drops the response and restarts at req0.
    do_reset();
    cyc(4'h4, 4'h0, 16'h0300, 32'h0);
    chk("rst_mid grant", 64'(REQ_READY), 64'h4);
    @(posedge CLK); #1;
    RESET = 1'b1; REQ_VALID = 4'hF; REQ_WRITE = 4'h0; REQ_ADDR = 16'h3333;
    #2;
    chk("rst_mid resp", 64'({RESP_VALID, REQ_READY}), 64'h0);
    cyc(4'hF, 4'h0, 16'h3333, 32'h0);
    chk("rst_mid after resp", 64'(RESP_VALID), 64'h0);
    chk("rst_mid after ready", 64'(REQ_READY), 64'h1);
    cyc(4'h0, 4'h0, 16'h0, 32'h0);
    chk("rst_mid req0 resp", 64'(RESP_VALID), 64'h1);
    chk("rst_mid req0 rdata", 64'(RESP_DATA), 64'h13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
